// File: rtl/onn_pattern_loader.sv
// Streams a stored (optionally noise-masked) binary pattern into the ONN input shift chain
// as a valid/ready beat stream, LANES bits per beat.
module onn_pattern_loader #(
  parameter int N_BITS    = 60,
  parameter int N_IMG     = 8,
  parameter int IMG_W     = (N_IMG > 1) ? $clog2(N_IMG) : 1,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter logic [N_IMG*N_BITS-1:0] PATTERNS = '0
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [IMG_W-1:0]  img_no,
  input  logic [N_BITS-1:0] noise_mask,
  input  logic              re,
  input  logic              start,
  input  logic              ready,
  output logic [LANES-1:0]  data_out,
  output logic              load,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NBEATS = N_BITS / LANES;
  localparam int CW     = $clog2(NBEATS + 1);

  generate
    if ((N_BITS % LANES) != 0) begin : g_lane_check
      $error("onn_pattern_loader: N_BITS must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t            state, state_n;
  logic [N_BITS-1:0] shreg, shreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              done_n, err_n;

  logic [N_BITS-1:0] rom_word, loaded, reversed, stream_word;
  logic              img_bad, accept, last_beat;

  // The shift register always holds the pattern in stream order (earliest bit at the top),
  // so LSB-first streaming is just a bit reversal at load time.
  always_comb begin
    rom_word = '0;
    for (int i = 0; i < N_IMG; i++) begin
      if (32'(img_no) == 32'(i)) rom_word = PATTERNS[i*N_BITS +: N_BITS];
    end
    img_bad = (32'(img_no) >= 32'(N_IMG));
    loaded  = rom_word ^ noise_mask;
    reversed = '0;
    for (int i = 0; i < N_BITS; i++) reversed[i] = loaded[N_BITS-1-i];
    stream_word = (MSB_FIRST != 0) ? loaded : reversed;
  end

  assign load      = (state == SHIFT) && start;
  assign busy      = (state != IDLE);
  assign data_out  = load ? shreg[N_BITS-1 -: LANES] : '0;
  assign accept    = load && ready && !re;
  assign last_beat = (cnt == CW'(NBEATS - 1));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // A new request overrides everything, including a stream in progress.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = err;
    if (re) begin
      shreg_n = stream_word;
      cnt_n   = '0;
      state_n = ARMED;
      err_n   = img_bad;
    end else begin
      case (state)
        ARMED: if (start) state_n = SHIFT;
        SHIFT: begin
          if (accept) begin
            shreg_n = shreg << LANES;
            cnt_n   = cnt + CW'(1);
            if (last_beat) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

endmodule

// File: tb/tb_onn_pattern_loader.sv
// Scoreboard bench for onn_pattern_loader: three configurations (serial MSB-first,
// 4-lane LSB-first, and a 6-image ROM for the out-of-range index case).
module tb_onn_pattern_loader;

  localparam logic [59:0] PA0 = 60'h3C5A96E1F00FF17;
  localparam logic [59:0] PA1 = 60'h880880880880880;
  localparam logic [59:0] PA2 = 60'hA5A5A5A5A5A5A5A;
  localparam logic [59:0] PB0 = 60'h123456789ABCDEF;
  localparam logic [59:0] PC3 = 60'hF0F0F0F0F0F0F0F;
  localparam logic [60*8-1:0] PAT_A = {{300{1'b0}}, PA2, PA1, PA0};
  localparam logic [60*8-1:0] PAT_B = {{420{1'b0}}, PB0};
  localparam logic [60*6-1:0] PAT_C = {{120{1'b0}}, PC3, {180{1'b0}}};

  logic        sclk, rst_n;
  logic [2:0]  img_no;
  logic [59:0] noise_mask;
  logic [2:0]  re_v;
  logic        start, ready;
  logic        data_a, data_c;
  logic [3:0]  data_b;
  logic [2:0]  load_v, busy_v, done_v, err_v;

  int          sel;
  logic [3:0]  data_s;
  logic        load_s, busy_s, done_s, err_s, re_s;

  int          total, bad;
  int          acc_cnt, done_cnt;
  logic [3:0]  exp_q[$];
  logic        hold_pend;
  logic [3:0]  held;

  onn_pattern_loader #(.N_BITS(60), .N_IMG(8), .LANES(1), .MSB_FIRST(1), .PATTERNS(PAT_A)) dutA (
    .sclk(sclk), .rst_n(rst_n), .img_no(img_no), .noise_mask(noise_mask), .re(re_v[0]),
    .start(start), .ready(ready), .data_out(data_a), .load(load_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .err(err_v[0]));

  onn_pattern_loader #(.N_BITS(60), .N_IMG(8), .LANES(4), .MSB_FIRST(0), .PATTERNS(PAT_B)) dutB (
    .sclk(sclk), .rst_n(rst_n), .img_no(img_no), .noise_mask(noise_mask), .re(re_v[1]),
    .start(start), .ready(ready), .data_out(data_b), .load(load_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .err(err_v[1]));

  onn_pattern_loader #(.N_BITS(60), .N_IMG(6), .LANES(1), .MSB_FIRST(1), .PATTERNS(PAT_C)) dutC (
    .sclk(sclk), .rst_n(rst_n), .img_no(img_no), .noise_mask(noise_mask), .re(re_v[2]),
    .start(start), .ready(ready), .data_out(data_c), .load(load_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .err(err_v[2]));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always_comb begin
    data_s = (sel == 1) ? data_b : {3'b000, (sel == 2) ? data_c : data_a};
    load_s = load_v[sel];
    busy_s = busy_v[sel];
    done_s = done_v[sel];
    err_s  = err_v[sel];
    re_s   = re_v[sel];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [59:0] romWord(input int s, input logic [2:0] img);
    logic [59:0] w;
    w = '0;
    case (s)
      0: case (img) 3'd0: w = PA0; 3'd1: w = PA1; 3'd2: w = PA2; default: w = '0; endcase
      1: if (img == 3'd0) w = PB0;
      default: if (img == 3'd3) w = PC3;
    endcase
    return w;
  endfunction

  // Beat b of the stream: lane LANES-1 carries the earliest stream bit of the beat.
  function automatic logic [3:0] expBeat(input int s, input logic [59:0] w, input int b);
    logic [3:0] r;
    int lanes, pos;
    r = '0;
    lanes = (s == 1) ? 4 : 1;
    for (int l = 0; l < lanes; l++) begin
      pos = b * lanes + (lanes - 1 - l);
      r[l] = (s == 1) ? w[pos] : w[59 - pos];
    end
    return r;
  endfunction

  always @(negedge sclk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (done_s) begin
        done_cnt++;
        checkOutput("done_after_last", 64'(exp_q.size()), 64'd0);
      end
      if (hold_pend && load_s) checkOutput("stable_hold", 64'(data_s), 64'(held));
      if (load_s && ready && !re_s) begin
        checkOutput("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) checkOutput("beat_data", 64'(data_s), 64'(exp_q.pop_front()));
        acc_cnt++;
      end
      hold_pend = load_s && !ready && !re_s;
      held = data_s;
    end
  end

  task automatic applyStimulus(input int s, input logic [2:0] img, input logic [59:0] mask);
    logic [59:0] w;
    int nb;
    @(posedge sclk); #1;
    sel = s;
    re_v[s] = 1'b1;
    img_no = img;
    noise_mask = mask;
    exp_q.delete();
    w = romWord(s, img) ^ mask;
    nb = (s == 1) ? 15 : 60;
    for (int b = 0; b < nb; b++) exp_q.push_back(expBeat(s, w, b));
    @(posedge sclk); #1;
    re_v[s] = 1'b0;
    checkOutput("busy_armed", 64'(busy_s), 64'd1);
  endtask

  task automatic waitDone(input int based, input int budget);
    int n;
    n = 0;
    while (done_cnt == based && n < budget) begin
      @(posedge sclk);
      n++;
    end
    checkOutput("done_seen", 64'(done_cnt != based), 64'd1);
    @(posedge sclk); #1;
  endtask

  task automatic runStream(input int s, input logic [2:0] img, input logic [59:0] mask,
                           input logic exp_err);
    int basea, based, nb;
    nb = (s == 1) ? 15 : 60;
    start = 1'b1;
    ready = 1'b1;
    basea = acc_cnt;
    based = done_cnt;
    applyStimulus(s, img, mask);
    checkOutput("err_flag", 64'(err_s), 64'(exp_err));
    waitDone(based, 200);
    checkOutput("beat_count", 64'(acc_cnt - basea), 64'(nb));
    checkOutput("done_pulses", 64'(done_cnt - based), 64'd1);
    checkOutput("busy_after", 64'(busy_s), 64'd0);
    checkOutput("idle_load", 64'(load_s), 64'd0);
    checkOutput("idle_data", 64'(data_s), 64'd0);
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_load"}, 64'(load_s), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy_s), 64'd0);
    checkOutput({tag, "_done"}, 64'(done_s), 64'd0);
    checkOutput({tag, "_err"},  64'(err_s),  64'd0);
    checkOutput({tag, "_data"}, 64'(data_s), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int basea, based, n;
    total = 0; bad = 0; acc_cnt = 0; done_cnt = 0;
    hold_pend = 1'b0; held = '0;
    rst_n = 1'b0; re_v = '0; start = 1'b0; ready = 1'b1;
    img_no = '0; noise_mask = '0; sel = 0;

    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkAllZero("reset");
    end
    @(posedge sclk); #1;
    rst_n = 1'b1;

    // Serial MSB-first stream of image 1, then a masked image 0.
    runStream(0, 3'd1, 60'h0, 1'b0);
    start = 1'b1;
    repeat (3) begin
      @(negedge sclk);
      checkOutput("idle_start_load", 64'(load_s), 64'd0);
    end
    start = 1'b0;
    runStream(0, 3'd0, 60'h1, 1'b0);

    // Backpressure and a 3-cycle pause mid-stream.
    start = 1'b1;
    ready = 1'b1;
    basea = acc_cnt;
    based = done_cnt;
    applyStimulus(0, 3'd2, 60'h0);
    for (int c = 0; c < 400 && done_cnt == based; c++) begin
      @(posedge sclk); #1;
      ready = (c % 2 == 0);
      start = !(c >= 20 && c < 23);
      @(negedge sclk);
      if (c >= 20 && c < 23) checkOutput("pause_load", 64'(load_s), 64'd0);
    end
    checkOutput("bp_done_seen", 64'(done_cnt != based), 64'd1);
    @(posedge sclk); #1;
    checkOutput("bp_beat_count", 64'(acc_cnt - basea), 64'd60);
    checkOutput("bp_done_pulses", 64'(done_cnt - based), 64'd1);
    start = 1'b0;
    ready = 1'b1;

    // Abort an image 1 stream around beat 20 with a request for image 2.
    start = 1'b1;
    basea = acc_cnt;
    applyStimulus(0, 3'd1, 60'h0);
    n = 0;
    while (acc_cnt - basea < 20 && n < 100) begin
      @(posedge sclk);
      n++;
    end
    checkOutput("abort_reached20", 64'(acc_cnt - basea >= 20), 64'd1);
    based = done_cnt;
    applyStimulus(0, 3'd2, 60'h0);
    basea = acc_cnt;
    waitDone(based, 200);
    checkOutput("abort_beat_count", 64'(acc_cnt - basea), 64'd60);
    checkOutput("abort_done_pulses", 64'(done_cnt - based), 64'd1);
    start = 1'b0;

    // Four lanes, LSB first.
    runStream(1, 3'd0, 60'h0, 1'b0);

    // Out-of-range index streams the mask alone; a valid index clears err.
    runStream(2, 3'd7, 60'hC3C3C3C3C3C3C3C, 1'b1);
    runStream(2, 3'd3, 60'h0, 1'b0);

    // Asynchronous reset in the middle of a stream.
    start = 1'b1;
    basea = acc_cnt;
    applyStimulus(2, 3'd7, 60'h9999999999999A5);
    checkOutput("rst_err_before", 64'(err_s), 64'd1);
    n = 0;
    while (acc_cnt - basea < 30 && n < 100) begin
      @(posedge sclk);
      n++;
    end
    @(posedge sclk); #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    exp_q.delete();
    @(posedge sclk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge sclk);
      checkOutput("post_rst_load", 64'(load_s), 64'd0);
      checkOutput("post_rst_busy", 64'(busy_s), 64'd0);
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
